// File: rtl/xtea_lane_engine_if.sv
// Handshake bundle for xtea_lane_engine.
//   Request side : in_valid/in_ready with decrypt, data_in (64*LANES), key_in (128)
//   Result side  : out_valid/out_ready with data_out (64*LANES)
//   Status       : busy
// The slave modport is the engine's view; master is the upstream/downstream view.
interface xtea_lane_engine_if #(
    parameter int LANES = 2
);
    logic                  in_valid;
    logic                  in_ready;
    logic                  decrypt;
    logic [64*LANES-1:0]   data_in;
    logic [127:0]          key_in;
    logic                  out_valid;
    logic                  out_ready;
    logic [64*LANES-1:0]   data_out;
    logic                  busy;

    modport master (
        output in_valid, decrypt, data_in, key_in, out_ready,
        input  in_ready, out_valid, data_out, busy
    );

    modport slave (
        input  in_valid, decrypt, data_in, key_in, out_ready,
        output in_ready, out_valid, data_out, busy
    );
endinterface

// File: rtl/xtea_lane_engine.sv
// Multi-lane XTEA encrypt/decrypt engine, one half-round per clock.
// LANES independent 64-bit blocks share one 128-bit key and run in lockstep
// for ROUNDS full cycles.
// Ports:
//   clock  - system clock
//   reset  - asynchronous, active-high reset
//   bus    - xtea_lane_engine_if.slave: request handshake (in_valid/in_ready,
//            decrypt, data_in, key_in), result handshake (out_valid/out_ready,
//            data_out) and busy status.
// Lane n packing: v0 = [64n+31:64n], v1 = [64n+63:64n+32].
module xtea_lane_engine #(
    parameter int          LANES  = 2,
    parameter int          ROUNDS = 32,
    parameter logic [31:0] DELTA  = 32'h9E3779B9
) (
    input  logic                  clock,
    input  logic                  reset,
    xtea_lane_engine_if.slave     bus
);

    localparam int          CW      = $clog2(ROUNDS + 1);
    localparam int          DW      = 64 * LANES;
    localparam logic [31:0] SUM_DEC = DELTA * 32'(ROUNDS);
    localparam logic [CW-1:0] LAST  = CW'(ROUNDS - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t         state_q, state_d;
    logic [31:0]    v0_q [LANES];
    logic [31:0]    v1_q [LANES];
    logic [31:0]    v0_d [LANES];
    logic [31:0]    v1_d [LANES];
    logic [31:0]    hr_v0 [LANES];
    logic [31:0]    hr_v1 [LANES];
    logic [31:0]    key_q [4];
    logic [31:0]    key_d [4];
    logic           dec_q, dec_d;
    logic           phase_q, phase_d;
    logic [31:0]    sum_q, sum_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [DW-1:0]  dout_q, dout_d;
    logic           oval_q, oval_d;

    logic [31:0]    kt;
    logic [31:0]    t;
    logic           upd_v0;

    function automatic logic [31:0] mix(input logic [31:0] x);
        return ((x << 4) ^ (x >> 5)) + x;
    endfunction

    // Half-round datapath. Encrypt phase 0 and decrypt phase 1 both update v0
    // from f(v1) with key word k[sum[1:0]]; the other two cases update v1 from
    // f(v0) with k[sum[12:11]]. Only the add/subtract differs.
    always_comb begin
        t      = '0;
        upd_v0 = (dec_q == phase_q);
        kt     = upd_v0 ? (sum_q + key_q[sum_q[1:0]])
                        : (sum_q + key_q[sum_q[12:11]]);
        for (int unsigned n = 0; n < LANES; n++) begin
            hr_v0[n] = v0_q[n];
            hr_v1[n] = v1_q[n];
            if (upd_v0) begin
                t        = mix(v1_q[n]) ^ kt;
                hr_v0[n] = dec_q ? (v0_q[n] - t) : (v0_q[n] + t);
            end else begin
                t        = mix(v0_q[n]) ^ kt;
                hr_v1[n] = dec_q ? (v1_q[n] - t) : (v1_q[n] + t);
            end
        end
    end

    // Next-state and outputs
    always_comb begin
        state_d = state_q;
        v0_d    = v0_q;
        v1_d    = v1_q;
        key_d   = key_q;
        dec_d   = dec_q;
        phase_d = phase_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        dout_d  = dout_q;
        oval_d  = oval_q;

        bus.in_ready  = (state_q == S_IDLE);
        bus.busy      = (state_q != S_IDLE);
        bus.out_valid = oval_q;
        bus.data_out  = dout_q;

        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    for (int unsigned n = 0; n < LANES; n++) begin
                        v0_d[n] = bus.data_in[64*n +: 32];
                        v1_d[n] = bus.data_in[64*n+32 +: 32];
                    end
                    for (int unsigned j = 0; j < 4; j++) begin
                        key_d[j] = bus.key_in[32*j +: 32];
                    end
                    dec_d   = bus.decrypt;
                    sum_d   = bus.decrypt ? SUM_DEC : '0;
                    cnt_d   = '0;
                    phase_d = 1'b0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                v0_d    = hr_v0;
                v1_d    = hr_v1;
                phase_d = ~phase_q;
                if (!phase_q) begin
                    sum_d = dec_q ? (sum_q - DELTA) : (sum_q + DELTA);
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                // The result register is loaded on the first DONE cycle, so
                // out_valid appears one clock after the final half-round.
                if (!oval_q) begin
                    oval_d = 1'b1;
                    for (int unsigned n = 0; n < LANES; n++) begin
                        dout_d[64*n +: 64] = {v1_q[n], v0_q[n]};
                    end
                end else if (bus.out_ready) begin
                    oval_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            v0_q    <= '{default: '0};
            v1_q    <= '{default: '0};
            key_q   <= '{default: '0};
            dec_q   <= 1'b0;
            phase_q <= 1'b0;
            sum_q   <= '0;
            cnt_q   <= '0;
            dout_q  <= '0;
            oval_q  <= 1'b0;
        end else begin
            v0_q    <= v0_d;
            v1_q    <= v1_d;
            key_q   <= key_d;
            dec_q   <= dec_d;
            phase_q <= phase_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
            oval_q  <= oval_d;
        end
    end

endmodule
